// File: rtl/stage_one_fetch.sv
// Instruction-fetch stage with IF/ID register, decode-driven redirects and a
// circular hardware return-address stack.
module stage_one_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          STACK_DEPTH = 8,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic [2:0]  pcSrc,
  input  logic        PCWrite,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] reg_target,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_one,
  output logic        valid,
  output logic        stack_overflow,
  output logic        stack_underflow
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0] SP_FULL = (AW+1)'(STACK_DEPTH);

  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] next_pc;
  logic [31:0] off_ext;
  logic [31:0] top;
  logic        redirect;
  logic        empty;
  logic        full;

  logic [31:0] ras [STACK_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] top_idx;
  logic [AW:0]   sp;

  assign imem_addr = pc;
  assign pc_inc    = pc + 32'd1;
  assign off_ext   = {{16{instruction[15]}}, instruction[15:0]};
  assign empty     = (sp == '0);
  assign full      = (sp == SP_FULL);
  assign top_idx   = head - 1'b1;
  assign top       = empty ? 32'd0 : ras[top_idx];
  assign redirect  = (pcSrc >= 3'd1) && (pcSrc <= 3'd4);

  always_comb begin
    next_pc = pc_inc;
    case (pcSrc)
      3'd1:    next_pc = pc_plus_one + off_ext;
      3'd2:    next_pc = {pc_plus_one[31:26], instruction[25:0]};
      3'd3:    next_pc = reg_target;
      3'd4:    next_pc = top;
      default: next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      instruction <= NOP_WORD;
      pc_plus_one <= 32'd0;
      valid       <= 1'b0;
    end else if (PCWrite) begin
      pc <= next_pc;
      if (redirect) begin
        instruction <= NOP_WORD;
        pc_plus_one <= 32'd0;
        valid       <= 1'b0;
      end else begin
        instruction <= imem_data;
        pc_plus_one <= pc_inc;
        valid       <= 1'b1;
      end
    end
  end

  // head is the next write slot; when full it points at the oldest entry,
  // so a push overwrites the oldest return address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) ras[i] <= 32'd0;
      head            <= '0;
      sp              <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (PCWrite) begin
      if (push && pop) begin
        if (empty) begin
          ras[head]       <= pc_plus_one;
          head            <= head + 1'b1;
          sp              <= (AW+1)'(1);
          stack_underflow <= 1'b1;
        end else begin
          ras[top_idx] <= pc_plus_one;
        end
      end else if (push) begin
        ras[head] <= pc_plus_one;
        head      <= head + 1'b1;
        if (full) stack_overflow <= 1'b1;
        else      sp <= sp + 1'b1;
      end else if (pop) begin
        if (empty) begin
          stack_underflow <= 1'b1;
        end else begin
          head <= top_idx;
          sp   <= sp - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage_one_fetch.sv
// Self-checking bench for stage_one_fetch: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_stage_one_fetch;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [2:0]  pcSrc = 3'd0;
  logic        PCWrite = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] reg_target = 32'd0;
  logic [31:0] instruction;
  logic [31:0] pc_plus_one;
  logic        valid;
  logic        stack_overflow;
  logic        stack_underflow;

  int checks = 0;
  int fails  = 0;
  int mem_mode = 0;

  logic [31:0] m_pc, m_instr, m_ppo;
  logic        m_valid, m_ovf, m_unf;
  logic [31:0] m_stack [$];

  stage_one_fetch #(
    .RESET_PC   (32'h0000_0000),
    .STACK_DEPTH(DEPTH),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .pcSrc          (pcSrc),
    .PCWrite        (PCWrite),
    .push           (push),
    .pop            (pop),
    .reg_target     (reg_target),
    .instruction    (instruction),
    .pc_plus_one    (pc_plus_one),
    .valid          (valid),
    .stack_overflow (stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  // Mode 0 is a small hand-built program; mode 1 is a hashed random image.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int mode);
    if (mode == 0) begin
      if (a == 32'd4) return 32'h1000_FFFE;
      if (a == 32'd8) return 32'h0800_0040;
      return a + 32'h100;
    end
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_data = mem_word(imem_addr, mem_mode);

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc = 32'd0; m_instr = 32'd0; m_ppo = 32'd0;
    m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_stack.delete();
  endtask

  task automatic modelStep(input logic [2:0] src, input logic pw, input logic pu,
                           input logic po, input logic [31:0] rt);
    logic [31:0] nxt, tp, v;
    int off;
    if (!pw) return;
    tp  = (m_stack.size() > 0) ? m_stack[$] : 32'd0;
    v   = m_ppo;
    off = $signed(m_instr[15:0]);
    case (src)
      3'd1:    nxt = m_ppo + off;
      3'd2:    nxt = (m_ppo & 32'hFC00_0000) | (m_instr & 32'h03FF_FFFF);
      3'd3:    nxt = rt;
      3'd4:    nxt = tp;
      default: nxt = m_pc + 1;
    endcase
    if (pu && po) begin
      if (m_stack.size() == 0) begin m_unf = 1'b1; m_stack.push_back(v); end
      else m_stack[m_stack.size()-1] = v;
    end else if (pu) begin
      if (m_stack.size() == DEPTH) begin void'(m_stack.pop_front()); m_ovf = 1'b1; end
      m_stack.push_back(v);
    end else if (po) begin
      if (m_stack.size() == 0) m_unf = 1'b1;
      else void'(m_stack.pop_back());
    end
    if (src >= 3'd1 && src <= 3'd4) begin
      m_instr = 32'd0; m_ppo = 32'd0; m_valid = 1'b0;
    end else begin
      m_instr = mem_word(m_pc, mem_mode); m_ppo = m_pc + 1; m_valid = 1'b1;
    end
    m_pc = nxt;
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ".pc"},    imem_addr,   m_pc);
    checkOutput({where, ".instr"}, instruction, m_instr);
    checkOutput({where, ".ppo"},   pc_plus_one, m_ppo);
    checkOutput({where, ".valid"}, valid,       m_valid);
    checkOutput({where, ".ovf"},   stack_overflow,  m_ovf);
    checkOutput({where, ".unf"},   stack_underflow, m_unf);
  endtask

  task automatic applyStimulus(input logic [2:0] src, input logic pw, input logic pu,
                               input logic po, input logic [31:0] rt);
    pcSrc = src; PCWrite = pw; push = pu; pop = po; reg_target = rt;
    checkOutput("pre.pc", imem_addr, m_pc);
    modelStep(src, pw, pu, po, rt);
    @(posedge clk);
    #1;
    checkAll("step");
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic asyncReset();
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkAll("async_rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'd0, 1'b1, 1'b0, 1'b0, 32'd0);
      if (i == 0) checkOutput("first_instr", instruction, 32'h100);
    end
    applyStimulus(3'd1, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("branch_target", imem_addr, 32'd3);
    checkOutput("branch_bubble", valid, 32'd0);

    for (int i = 0; i < 6; i++) applyStimulus(3'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(3'd2, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("call_target", imem_addr, 32'h40);
    for (int i = 0; i < 3; i++) applyStimulus(3'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(3'd4, 1'b1, 1'b0, 1'b1, 32'd0);
    checkOutput("return_target", imem_addr, 32'd9);

    for (int i = 0; i < 3; i++) applyStimulus(3'd3, 1'b0, 1'b1, 1'b1, 32'h77);
    applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 32'h77);
    checkOutput("jr_target", imem_addr, 32'h77);

    for (int i = 0; i < 9; i++) applyStimulus(3'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("overflow_flag", stack_overflow, 32'd1);
    applyStimulus(3'd4, 1'b1, 1'b0, 1'b1, 32'd0);

    asyncReset();
    applyStimulus(3'd4, 1'b1, 1'b0, 1'b1, 32'd0);
    checkOutput("empty_pop_pc", imem_addr, 32'd0);
    checkOutput("underflow_flag", stack_underflow, 32'd1);

    mem_mode = 1;
    for (int i = 0; i < 400; i++) begin
      int s;
      s = $urandom_range(0, 11);
      applyStimulus((s > 7) ? 3'd0 : 3'(s), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), $urandom);
      if (i % 100 == 99) asyncReset();
    end

    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
